rr_grant_stage: RTL
===================

Name: rr_grant_stage

Overview:
- Downstream stage of thermometer_priority_mask in the round-robin arbiter.
- Consumes raw req plus the masked request vector mask_req, picks one winner, registers a one-hot grant and holds it until the owner releases.
- Returns last_grant to the mask stage so it can advance its round-robin pointer.

Parameters:
N, 4, number of requesters (N >= 2)
IDW, $clog2(N), width of grant_id (derived, not overridden)
HOLD_MAX, 16, maximum grant-hold cycles; used only when the timeout feature is compiled in

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  raw request vector, bit i = requester i
mask_req  input  N  masked requests from thermometer_priority_mask (bits above last winner)
done  input  1  current owner finished; releases grant
grant  output  N  registered one-hot grant, all zero when idle
grant_valid  output  1  high while any grant is held (equals |grant)
grant_id  output  IDW  binary index of grant; holds last value when grant_valid=0
last_grant  output  N  one-hot of most recently released owner, fed back to mask stage
timeout  output  1  one-cycle pulse on forced release; constant 0 without the timeout feature

Behaviour:
- Reset, sampled at a clk edge while rst=1:
  - state=IDLE, grant=0, grant_valid=0, grant_id=0.
  - last_grant = 1 << (N-1), so requester 0 has first priority after reset.
  - timeout=0.
  - Reset asserted mid-grant drops grant at that same edge; no last_grant update occurs.
- Selection, combinational, evaluated in IDLE only:
  - eff = mask_req & req. Bits of mask_req not present in req are ignored.
  - If eff != 0, winner = lowest set bit of eff; otherwise winner = lowest set bit of req.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, register grant = winner one-hot and grant_id = its index, then go to GRANT.
  - Latency: req sampled at edge k, grant visible after edge k.
  - If req == 0, stay in IDLE with outputs unchanged.
  - done is ignored in IDLE.
- GRANT:
  - Hold grant and grant_id unchanged; req/mask_req changes on other bits have no effect.
  - Release condition: done=1, or req[grant_id]=0. Both together count as a single release.
  - On release: grant=0, last_grant=grant, go to IDLE.
  - Release always produces exactly one cycle with grant_valid=0 before the next grant. No back-to-back grants.
- The mask stage must present mask_req derived from the updated last_grant by the IDLE evaluation cycle. The bench checks this pairing.
- grant is always one-hot or zero. grant_valid == |grant in every cycle (assertion).

Optional Feature:
Macro: RR_GRANT_TIMEOUT_EN
- Defined:
  - A hold counter of width $clog2(HOLD_MAX+1) clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches HOLD_MAX with no release, force a release: grant=0, last_grant=grant, state IDLE, timeout=1 for one cycle.
  - A normal release in the same cycle takes precedence, with timeout=0.
  - Counter is cleared by rst.
- Not defined: no counter; timeout tied to 0; grant is held indefinitely.

Decomposition:
- Package rr_arb_pkg:
  - state enum (IDLE, GRANT).
  - Default N.
  - Function lowest_onehot(vec).
  - Function onehot2idx(onehot).
- One sub-module: rr_fixed_prio_pick, a combinational lowest-index picker (N-bit in, N-bit one-hot out, any-bit flag). Instantiated twice, for eff and for req.

Test Plan:
1. Reset: rst=1 for 2 edges, then 0 -> grant=0000, grant_valid=0, grant_id=0, last_grant=1000, timeout=0.
2. req=0001, mask_req=0000 -> next edge grant=0001, grant_id=0; done=1 for one cycle -> next edge grant=0000, last_grant=0001.
3. req=1111, mask_req=1110 -> grant=0010. Pulse done -> one idle cycle. With mask_req=1100 -> grant=0100, grant_id=2, last_grant=0010.
4. Wrap-around: req=0011, mask_req=0000 -> grant=0001 (lowest raw bit). Also req=1010 with mask_req=0101 -> eff=0000, so grant=0010.
5. Owner drops: grant=1000 held, req goes 1111 -> 0111 with done=0 -> next edge grant=0000, last_grant=1000. Also hold done=1 with req[id]=0 in the same cycle -> single release.
6. With RR_GRANT_TIMEOUT_EN and HOLD_MAX=4: req=0100 held, done=0 -> grant held 4 cycles, then grant=0000, timeout=1 for one cycle, then re-granted 0100. Assert rst during GRANT -> grant=0000 on that edge, last_grant=1000.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin arbiter slice.
//   state_t        : grant-stage FSM states (IDLE, GRANT)
//   DEFAULT_N      : default number of requesters
//   MAX_N          : widest vector the helper functions accept
//   lowest_onehot  : isolates the lowest set bit of a vector
//   onehot2idx     : binary index of a one-hot vector (0 for all-zero)
package rr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int unsigned DEFAULT_N = 4;
   localparam int unsigned MAX_N     = 64;

   // Two's-complement trick: vec & -vec keeps only the lowest set bit.
   function automatic logic [MAX_N-1:0] lowest_onehot(input logic [MAX_N-1:0] vec);
      return vec & (~vec + MAX_N'(1));
   endfunction

   // OR of the indices of all set bits; exact for one-hot input.
   function automatic int unsigned onehot2idx(input logic [MAX_N-1:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (onehot[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_fixed_prio_pick.sv
// rr_fixed_prio_pick: combinational fixed-priority picker, lowest index wins.
//   vec    : N-bit request vector
//   onehot : N-bit one-hot of the lowest set bit of vec (zero if none)
//   any    : high when vec has at least one bit set
module rr_fixed_prio_pick
   import rr_arb_pkg::*;
#(
   parameter int unsigned N = DEFAULT_N
) (
   input  logic [N-1:0] vec,
   output logic [N-1:0] onehot,
   output logic         any
);

   always_comb begin
      onehot = N'(lowest_onehot(MAX_N'(vec)));
      any    = |vec;
   end

endmodule

// File: rtl/rr_grant_stage.sv
// rr_grant_stage: grant stage of the round-robin arbiter. Picks a winner from
// the masked requests (falling back to raw requests), registers a one-hot
// grant and holds it until the owner releases. The released owner is returned
// on last_grant so the mask stage can advance its pointer.
// Optional forced release after HOLD_MAX cycles: define RR_GRANT_TIMEOUT_EN.
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset
//   req         : raw request vector
//   mask_req    : requests above the last winner, from the mask stage
//   done        : current owner finished
//   grant       : registered one-hot grant, zero when idle
//   grant_valid : high while a grant is held
//   grant_id    : binary index of grant, holds last value when idle
//   last_grant  : one-hot of the most recently released owner
//   timeout     : one-cycle pulse on forced release (0 without the feature)
module rr_grant_stage
   import rr_arb_pkg::*;
#(
   parameter int unsigned N        = DEFAULT_N,
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         mask_req,
   input  logic                 done,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [N-1:0]         last_grant,
   output logic                 timeout
);

   localparam int unsigned IDW = $clog2(N);

   if (N < 2 || N > MAX_N || HOLD_MAX < 1) begin : g_bad_cfg
      $error("rr_grant_stage: need 2 <= N <= MAX_N and HOLD_MAX >= 1");
   end

   state_t         state;
   logic [N-1:0]   eff;
   logic [N-1:0]   eff_oh;
   logic [N-1:0]   req_oh;
   logic           eff_any;
   logic           req_any;
   logic [N-1:0]   winner;
   logic [IDW-1:0] winner_id;
   logic           owner_done;
   logic           hold_expired;

   assign eff = mask_req & req;

   rr_fixed_prio_pick #(.N(N)) u_pick_eff (
      .vec    (eff),
      .onehot (eff_oh),
      .any    (eff_any)
   );

   rr_fixed_prio_pick #(.N(N)) u_pick_req (
      .vec    (req),
      .onehot (req_oh),
      .any    (req_any)
   );

   always_comb begin
      winner     = eff_any ? eff_oh : req_oh;
      winner_id  = IDW'(onehot2idx(MAX_N'(winner)));
      owner_done = done | ~req[grant_id];
   end

`ifdef RR_GRANT_TIMEOUT_EN
   localparam int unsigned CW = $clog2(HOLD_MAX + 1);

   logic [CW-1:0] hold_cnt;

   // Count sits at 0 on the first GRANT cycle, so HOLD_MAX-1 marks the last
   // permitted cycle: the grant is visible for exactly HOLD_MAX cycles.
   assign hold_expired = (hold_cnt == CW'(HOLD_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         // A normal release in the same cycle wins, so no pulse then.
         timeout <= (state == GRANT) && !owner_done && hold_expired;
         if (state == GRANT) hold_cnt <= hold_cnt + CW'(1);
         else                hold_cnt <= '0;
      end
   end
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         last_grant  <= {1'b1, {(N-1){1'b0}}};
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant       <= winner;
                  grant_valid <= 1'b1;
                  grant_id    <= winner_id;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               // Releasing always lands in IDLE, which guarantees one empty
               // cycle before the next grant.
               if (owner_done || hold_expired) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  last_grant  <= grant;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_valid_matches: assert property (@(posedge clk) grant_valid == (|grant));
   a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));

endmodule
